vector_add_sub_pipe: RTL and testbench
======================================

// Module: vector_add_sub_pipe
// PURPOSE
//  LANES-wide SIMD two's-complement adder/subtractor for the vector execute stage; each lane is WIDTH bits.
//  Successor of the scalar adder/subtractor: adds signed saturating modes, per-lane masking,
//  per-lane N/Z/C/V flags and a 2-stage pipeline with valid/ready flow control on input and output.
// PARAMETERS
//  WIDTH  19  bits per lane (>=2)
//  LANES  4   number of parallel lanes (>=1)
// PORTS
//  clk        in   1            single clock; all state updates on rising edge
//  rst        in   1            synchronous, active-high reset
//  in_valid   in   1            operand bundle present
//  in_ready   out  1            block accepts bundle this cycle (accept = in_valid & in_ready)
//  op         in   2            00 add, 01 sub, 10 add-sat (signed), 11 sub-sat (signed)
//  lane_mask  in   LANES        1 = lane active; 0 = lane passes A through
//  a          in   LANES*WIDTH  operand A, lane i at [i*WIDTH +: WIDTH]
//  b          in   LANES*WIDTH  operand B, same packing
//  out_valid  out  1            result bundle present
//  out_ready  in   1            consumer takes bundle (retire = out_valid & out_ready)
//  result     out  LANES*WIDTH  per-lane result, same packing
//  flag_n     out  LANES        per-lane negative (MSB of result)
//  flag_z     out  LANES        per-lane zero (result == 0)
//  flag_c     out  LANES        per-lane carry-out of MSB of raw sum
//  flag_v     out  LANES        per-lane signed overflow of raw sum
//  any_v      out  1            OR of flag_v over all lanes
// BEHAVIOUR
//  Reset: out_valid=0, result/flags/any_v=0, both stage valids=0; in_ready=1 in the first cycle after rst drops.
//  rst asserted mid-operation: all in-flight bundles discarded at that edge, no output produced for them.
//  Pipeline: S1 registers a, b, op, lane_mask on accept; S2 registers result+flags from S1 contents.
//  Latency: accept in cycle t -> out_valid=1 in cycle t+2 when no backpressure; throughput 1 bundle/cycle.
//  Flow control: s2_adv = ~out_valid | out_ready; s1_adv = ~s1_valid | s2_adv; in_ready = s1_adv (combinational).
//   in_ready must not depend on in_valid. Bundles exit in order; none lost, none duplicated.
//   While out_valid & ~out_ready: result and flags held stable; S1 holds; after 2 unretired bundles in_ready=0.
//  Arithmetic per active lane: sub = op[0]; raw = A + (B ^ {WIDTH{sub}}) + sub, computed WIDTH+1 wide.
//   flag_c = raw[WIDTH] (sub: 1 = no borrow); flag_v = (A[MSB] == Bx[MSB]) & (raw[MSB] != A[MSB]), Bx = B ^ {WIDTH{sub}}.
//   op[1]=0: result = raw[WIDTH-1:0] (wraps).
//   op[1]=1 and flag_v: result = A[MSB] ? 1 followed by WIDTH-1 zeros (min neg) : 0 followed by WIDTH-1 ones (max pos);
//    otherwise result = raw.
//   flag_n, flag_z taken from final (post-saturation) result; flag_c, flag_v from raw sum.
//  Masked lane (lane_mask[i]=0): result = A lane unchanged; all four flags of that lane = 0; excluded from any_v.
//  Edge cases: B=0 sub -> C=1, V=0; A=B sub -> Z=1, C=1; min_neg - 1 overflows (V=1); min_neg - min_neg = 0, V=0.
//  Simultaneous accept and retire in the same cycle with both stages full: both advance, no bubble inserted.
// TESTING (WIDTH=19, LANES=4, mask=1111 unless stated)
//  1 rst high 2 cycles, in_valid=1 -> out_valid=0, result=0, in_ready=1 the cycle after rst drops; no output appears.
//  2 op=00 lane0 a=5 b=3; op=01 lane1 a=b=0x12345 -> 2 cycles later lane0=8 (C=0,V=0,Z=0), lane1=0 (Z=1,C=1).
//  3 a=0x3FFFF b=1: op=00 -> 0x40000, N=1, V=1; op=10 -> 0x3FFFF, N=0, V=1, any_v=1.
//  4 a=0x40000 b=1: op=11 -> 0x40000, V=1; op=01 -> 0x3FFFF, V=1; a=b=0x40000 op=11 -> 0, Z=1, V=0.
//  5 mask=0101, op=00, a=0x10 b=0x20 in all lanes -> lanes0,2=0x30; lanes1,3=0x10 with all flags 0.
//  6 5 back-to-back bundles, out_ready=0 for 6 cycles, then 1 -> in_ready=0 after 2 accepts, held outputs stable, 5 in order.

Source files
------------

// File: rtl/vector_add_sub_pipe_if.sv
// Operand/result bundle with valid/ready handshakes on both sides of the vector add/sub pipe.
interface vector_add_sub_pipe_if #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned LANES = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               op;
    logic [LANES-1:0]         lane_mask;
    logic [LANES*WIDTH-1:0]   a;
    logic [LANES*WIDTH-1:0]   b;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*WIDTH-1:0]   result;
    logic [LANES-1:0]         flag_n;
    logic [LANES-1:0]         flag_z;
    logic [LANES-1:0]         flag_c;
    logic [LANES-1:0]         flag_v;
    logic                     any_v;

    modport master (
        output in_valid, op, lane_mask, a, b, out_ready,
        input  in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v, any_v
    );

    modport slave (
        input  in_valid, op, lane_mask, a, b, out_ready,
        output in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v, any_v
    );
endinterface

// File: rtl/vector_add_sub_pipe.sv
// Two-stage SIMD add/sub with signed saturation, lane masking and per-lane N/Z/C/V flags.
module vector_add_sub_pipe #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned LANES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    vector_add_sub_pipe_if.slave  pipe_if
);
    localparam int unsigned VW  = LANES * WIDTH;
    localparam int unsigned MSB = WIDTH - 1;

    logic               s1_valid_q;
    logic [VW-1:0]      s1_a_q;
    logic [VW-1:0]      s1_b_q;
    logic [1:0]         s1_op_q;
    logic [LANES-1:0]   s1_mask_q;

    logic               s2_valid_q;
    logic [VW-1:0]      res_q,  res_d;
    logic [LANES-1:0]   n_q,    n_d;
    logic [LANES-1:0]   z_q,    z_d;
    logic [LANES-1:0]   c_q,    c_d;
    logic [LANES-1:0]   v_q,    v_d;
    logic               any_v_q;

    logic               s1_adv;
    logic               s2_adv;
    logic               accept;

    logic [WIDTH-1:0]   la  [LANES];
    logic [WIDTH-1:0]   bx  [LANES];
    logic [WIDTH:0]     raw [LANES];
    logic [WIDTH-1:0]   lr  [LANES];
    logic [LANES-1:0]   ovf;

    assign s2_adv = ~s2_valid_q | pipe_if.out_ready;
    assign s1_adv = ~s1_valid_q | s2_adv;
    assign accept = pipe_if.in_valid & s1_adv;

    // Per-lane raw sum, overflow detection, saturation and masking of the S1 contents.
    always_comb begin
        res_d = '0;
        n_d   = '0;
        z_d   = '0;
        c_d   = '0;
        v_d   = '0;
        ovf   = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            la[i]  = s1_a_q[i*WIDTH +: WIDTH];
            bx[i]  = s1_b_q[i*WIDTH +: WIDTH] ^ {WIDTH{s1_op_q[0]}};
            raw[i] = {1'b0, la[i]} + {1'b0, bx[i]} + (WIDTH+1)'(s1_op_q[0]);
            ovf[i] = (la[i][MSB] == bx[i][MSB]) & (raw[i][MSB] != la[i][MSB]);
            if (s1_op_q[1] && ovf[i]) begin
                lr[i] = la[i][MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                lr[i] = raw[i][WIDTH-1:0];
            end
            if (s1_mask_q[i]) begin
                res_d[i*WIDTH +: WIDTH] = lr[i];
                n_d[i] = lr[i][MSB];
                z_d[i] = (lr[i] == '0);
                c_d[i] = raw[i][WIDTH];
                v_d[i] = ovf[i];
            end else begin
                res_d[i*WIDTH +: WIDTH] = la[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s1_mask_q  <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            n_q        <= '0;
            z_q        <= '0;
            c_q        <= '0;
            v_q        <= '0;
            any_v_q    <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= pipe_if.in_valid;
                if (accept) begin
                    s1_a_q    <= pipe_if.a;
                    s1_b_q    <= pipe_if.b;
                    s1_op_q   <= pipe_if.op;
                    s1_mask_q <= pipe_if.lane_mask;
                end
            end
            // S2 only reloads when it advances, so a stalled result stays stable.
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    res_q   <= res_d;
                    n_q     <= n_d;
                    z_q     <= z_d;
                    c_q     <= c_d;
                    v_q     <= v_d;
                    any_v_q <= |v_d;
                end
            end
        end
    end

    assign pipe_if.in_ready  = s1_adv;
    assign pipe_if.out_valid = s2_valid_q;
    assign pipe_if.result    = res_q;
    assign pipe_if.flag_n    = n_q;
    assign pipe_if.flag_z    = z_q;
    assign pipe_if.flag_c    = c_q;
    assign pipe_if.flag_v    = v_q;
    assign pipe_if.any_v     = any_v_q;
endmodule

// File: tb/tb_vector_add_sub_pipe.sv
// Self-checking bench: directed vector table, reset/backpressure sequences and randomized traffic.
module tb_vector_add_sub_pipe;
    localparam int unsigned W  = 19;
    localparam int unsigned L  = 4;
    localparam int unsigned VW = W * L;

    typedef struct packed {
        logic [VW-1:0] res;
        logic [L-1:0]  n;
        logic [L-1:0]  z;
        logic [L-1:0]  c;
        logic [L-1:0]  v;
        logic          anyv;
    } exp_t;

    typedef struct packed {
        logic [1:0]    op;
        logic [L-1:0]  mask;
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        exp_t          e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    vec_t tbl[9];
    logic rand_done;

    vector_add_sub_pipe_if #(.WIDTH(W), .LANES(L)) bus ();

    vector_add_sub_pipe #(.WIDTH(W), .LANES(L)) dut (
        .clk     (clk),
        .rst     (rst),
        .pipe_if (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] rep(input logic [W-1:0] x);
        return {L{x}};
    endfunction

    // Reference: exact signed arithmetic, clamped or wrapped into W bits.
    function automatic exp_t model(input logic [1:0] op, input logic [L-1:0] mask,
                                   input logic [VW-1:0] a, input logic [VW-1:0] b);
        exp_t   e;
        longint ua, ub, sa, sb, ex, r, maxp, minn, modv;
        logic   ov;
        e    = '0;
        modv = longint'(1) << W;
        maxp = (longint'(1) << (W-1)) - 1;
        minn = -(longint'(1) << (W-1));
        for (int i = 0; i < int'(L); i++) begin
            ua = longint'(a[i*W +: W]);
            ub = longint'(b[i*W +: W]);
            if (!mask[i]) begin
                e.res[i*W +: W] = a[i*W +: W];
            end else begin
                sa = (ua > maxp) ? ua - modv : ua;
                sb = (ub > maxp) ? ub - modv : ub;
                ex = op[0] ? sa - sb : sa + sb;
                ov = (ex > maxp) || (ex < minn);
                r  = (op[1] && ov) ? ((ex > maxp) ? maxp : minn) : ex;
                e.res[i*W +: W] = r[W-1:0];
                e.n[i] = r[W-1];
                e.z[i] = (r[W-1:0] == '0);
                e.c[i] = op[0] ? (ua >= ub) : (ua + ub >= modv);
                e.v[i] = ov;
                e.anyv = e.anyv | ov;
            end
        end
        return e;
    endfunction

    function automatic vec_t mk(input logic [1:0] op, input logic [L-1:0] mask,
                                input logic [VW-1:0] a, input logic [VW-1:0] b,
                                input logic [VW-1:0] res, input logic [L-1:0] n,
                                input logic [L-1:0] z, input logic [L-1:0] c,
                                input logic [L-1:0] v, input logic anyv);
        vec_t t;
        t.op = op; t.mask = mask; t.a = a; t.b = b;
        t.e.res = res; t.e.n = n; t.e.z = z; t.e.c = c; t.e.v = v; t.e.anyv = anyv;
        return t;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [L-1:0] mask,
                        input logic [VW-1:0] a, input logic [VW-1:0] b, input exp_t e);
        logic done;
        done = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.lane_mask = mask;
        bus.a         = a;
        bus.b         = b;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (!done) chk("accept_timeout", 128'(0), 128'(1));
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        chk("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    // Scoreboard: every retired bundle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 128'(1), 128'(0));
            end else begin
                exp_t e;
                exp_t g;
                e = exp_q.pop_front();
                g.res = bus.result; g.n = bus.flag_n; g.z = bus.flag_z;
                g.c = bus.flag_c; g.v = bus.flag_v; g.anyv = bus.any_v;
                chk("retire_bundle", 128'(g), 128'(e));
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b1;
        bus.op        = 2'b00;
        bus.lane_mask = 4'hF;
        bus.a         = rep(19'h5);
        bus.b         = rep(19'h3);
        bus.out_ready = 1'b1;
        rand_done     = 1'b0;

        tbl[0] = mk(2'b00, 4'hF, rep(19'h5), rep(19'h3), rep(19'h8), 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        tbl[1] = mk(2'b01, 4'hF, rep(19'h12345), rep(19'h12345), '0, 4'h0, 4'hF, 4'hF, 4'h0, 1'b0);
        tbl[2] = mk(2'b00, 4'hF, rep(19'h3FFFF), rep(19'h1), rep(19'h40000), 4'hF, 4'h0, 4'h0, 4'hF, 1'b1);
        tbl[3] = mk(2'b10, 4'hF, rep(19'h3FFFF), rep(19'h1), rep(19'h3FFFF), 4'h0, 4'h0, 4'h0, 4'hF, 1'b1);
        tbl[4] = mk(2'b11, 4'hF, rep(19'h40000), rep(19'h1), rep(19'h40000), 4'hF, 4'h0, 4'hF, 4'hF, 1'b1);
        tbl[5] = mk(2'b01, 4'hF, rep(19'h40000), rep(19'h1), rep(19'h3FFFF), 4'h0, 4'h0, 4'hF, 4'hF, 1'b1);
        tbl[6] = mk(2'b11, 4'hF, rep(19'h40000), rep(19'h40000), '0, 4'h0, 4'hF, 4'hF, 4'h0, 1'b0);
        tbl[7] = mk(2'b00, 4'b0101, rep(19'h10), rep(19'h20),
                    {19'h10, 19'h30, 19'h10, 19'h30}, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        tbl[8] = mk(2'b01, 4'hF, rep(19'h123), '0, rep(19'h123), 4'h0, 4'h0, 4'hF, 4'h0, 1'b0);

        // Reset held with in_valid high: nothing may emerge.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_result",    128'(bus.result),    128'(0));
        chk("rst_flags",     128'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v, bus.any_v}), 128'(0));
        chk("rst_in_ready",  128'(bus.in_ready),  128'(1));
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_output", 128'(bus.out_valid), 128'(0));
        end

        // Bundle in flight when reset hits is discarded.
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_output", 128'(bus.out_valid), 128'(0));
        end

        // Directed table, back to back.
        @(posedge clk); #1;
        for (int k = 0; k < 9; k++) send(tbl[k].op, tbl[k].mask, tbl[k].a, tbl[k].b, tbl[k].e);
        drain();

        // Two-cycle latency.
        @(posedge clk); #1;
        send(2'b00, 4'hF, rep(19'h7), rep(19'h9), model(2'b00, 4'hF, rep(19'h7), rep(19'h9)));
        @(negedge clk);
        chk("latency_t1", 128'(bus.out_valid), 128'(0));
        @(negedge clk);
        chk("latency_t2", 128'(bus.out_valid), 128'(1));
        drain();

        // Five bundles against six cycles of backpressure.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    logic [1:0]    op;
                    logic [VW-1:0] a, b;
                    op = 2'(k);
                    a  = rep(19'(32'h3FFF0 + 32'(k)));
                    b  = rep(19'(32'h11 * 32'(k + 1)));
                    send(op, 4'hF, a, b, model(op, 4'hF, a, b));
                end
            end
            begin
                repeat (3) @(negedge clk);
                chk("bp_in_ready_low", 128'(bus.in_ready),  128'(0));
                chk("bp_out_valid",    128'(bus.out_valid), 128'(1));
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_result_held", 128'(bus.result), 128'(exp_q[0].res));
                end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Random traffic with random backpressure.
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    logic [1:0]    op;
                    logic [L-1:0]  m;
                    logic [VW-1:0] a, b;
                    op = 2'($urandom_range(0, 3));
                    m  = 4'($urandom_range(0, 15));
                    for (int j = 0; j < int'(L); j++) begin
                        a[j*W +: W] = ($urandom_range(0, 3) == 0) ? 19'h40000 : 19'($urandom);
                        b[j*W +: W] = ($urandom_range(0, 3) == 0) ? 19'h3FFFF : 19'($urandom);
                    end
                    send(op, m, a, b, model(op, m, a, b));
                end
                rand_done = 1'b1;
            end
            begin
                for (int i = 0; i < 2000 && !rand_done; i++) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
